// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/memory-wait hazard control FSM; optional statistics counters via HAZARD_STATS_EN
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rt,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_branch_taken,
    input  logic        i_dmem_busy,
    input  logic        i_stats_clr,
    output logic        o_pc_write,
    output logic        o_if_id_write,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_pipe_freeze,
    output logic [1:0]  o_state,
    output logic        o_timeout_err,
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_flush_count
);
    typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, MEM_WAIT = 2'b10, ILLEGAL = 2'b11} state_t;
    localparam logic [7:0] TO = TIMEOUT[7:0];
    state_t     r_state, w_next;
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;
    logic       w_hazard;
    assign w_hazard = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end
    // All legal states share one decision tree; only the illegal encoding differs.
    always_comb begin
        w_next        = RUN;
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_pipe_freeze = 1'b0;
        if (r_state != ILLEGAL) begin
            if (i_dmem_busy) begin
                o_pc_write    = 1'b0;
                o_if_id_write = 1'b0;
                o_pipe_freeze = 1'b1;
                w_next        = MEM_WAIT;
            end else if (w_hazard) begin
                o_pc_write    = 1'b0;
                o_if_id_write = 1'b0;
                o_id_ex_flush = 1'b1;
                w_next        = LOAD_STALL;
            end else if (i_branch_taken) begin
                o_if_id_flush = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else if (i_dmem_busy) begin
            r_wait_cnt <= (r_wait_cnt >= TO) ? TO : r_wait_cnt + 8'd1;
            if (r_wait_cnt >= TO - 8'd1) r_timeout_err <= 1'b1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end
    assign o_state       = r_state;
    assign o_timeout_err = r_timeout_err;
`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles, r_flush_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else if (i_stats_clr) begin
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (!o_pc_write && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
            if (o_if_id_flush && r_flush_count != 16'hFFFF) r_flush_count <= r_flush_count + 16'd1;
        end
    end
    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`else
    logic w_unused;
    assign w_unused       = i_stats_clr;
    assign o_stall_cycles = 16'd0;
    assign o_flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard control with TIMEOUT=4
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, ex_mem_read, branch_taken, dmem_busy, stats_clr;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, timeout_err;
    logic [1:0]  state;
    logic [15:0] stall_cycles, flush_count;
    int          checks = 0, fails = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
        .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_branch_taken(branch_taken),
        .i_dmem_busy(dmem_busy), .i_stats_clr(stats_clr), .o_pc_write(pc_write),
        .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_pipe_freeze(pipe_freeze), .o_state(state), .o_timeout_err(timeout_err),
        .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; dmem_busy = 1'b0; stats_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    endtask

    function automatic logic [15:0] st(input logic [15:0] n);
        return STATS ? n : 16'd0;
    endfunction

    initial begin
        idle();
        #3;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pc", 16'(pc_write), 16'd1);
        chk("rst_ifidw", 16'(if_id_write), 16'd1);
        chk("rst_ifidfl", 16'(if_id_flush), 16'd0);
        chk("rst_idexfl", 16'(id_ex_flush), 16'd0);
        chk("rst_freeze", 16'(pipe_freeze), 16'd0);
        chk("rst_terr", 16'(timeout_err), 16'd0);
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_flush", flush_count, 16'd0);
        tick();
        rst = 1'b0;
        load_use(); #1;
        chk("lu_pc", 16'(pc_write), 16'd0);
        chk("lu_ifidw", 16'(if_id_write), 16'd0);
        chk("lu_idexfl", 16'(id_ex_flush), 16'd1);
        chk("lu_freeze", 16'(pipe_freeze), 16'd0);
        tick(); idle(); #1;
        chk("lu_state", 16'(state), 16'd1);
        chk("lu_pc_next", 16'(pc_write), 16'd1);
        tick();
        chk("lu_back", 16'(state), 16'd0);
        ex_mem_read = 1'b1; #1;
        chk("r0_pc", 16'(pc_write), 16'd1);
        chk("r0_idexfl", 16'(id_ex_flush), 16'd0);
        tick();
        chk("r0_state", 16'(state), 16'd0);
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; #1;
        chk("rt_unused_pc", 16'(pc_write), 16'd1);
        id_uses_rt = 1'b1; #1;
        chk("rt_used_pc", 16'(pc_write), 16'd0);
        tick();
        chk("rt_state", 16'(state), 16'd1);
        branch_taken = 1'b1; #1;
        chk("lub_pc", 16'(pc_write), 16'd0);
        chk("lub_ifidfl", 16'(if_id_flush), 16'd0);
        chk("lub_idexfl", 16'(id_ex_flush), 16'd1);
        tick();
        chk("lub_state", 16'(state), 16'd1);
        idle(); branch_taken = 1'b1; #1;
        chk("br_ifidfl", 16'(if_id_flush), 16'd1);
        chk("br_pc", 16'(pc_write), 16'd1);
        chk("br_ifidw", 16'(if_id_write), 16'd1);
        tick();
        chk("br_state", 16'(state), 16'd0);
        chk("br_stall", stall_cycles, st(16'd3));
        chk("br_flush", flush_count, st(16'd1));
        dmem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_freeze", 16'(pipe_freeze), 16'd1);
            chk("mw_pc", 16'(pc_write), 16'd0);
            chk("mw_ifidw", 16'(if_id_write), 16'd0);
            chk("mw_ifidfl", 16'(if_id_flush), 16'd0);
            tick();
            chk("mw_state", 16'(state), 16'd2);
        end
        dmem_busy = 1'b0; #1;
        chk("rel_ifidfl", 16'(if_id_flush), 16'd1);
        chk("rel_freeze", 16'(pipe_freeze), 16'd0);
        chk("rel_pc", 16'(pc_write), 16'd1);
        tick();
        chk("rel_state", 16'(state), 16'd0);
        chk("rel_terr", 16'(timeout_err), 16'd0);
        chk("rel_stall", stall_cycles, st(16'd6));
        chk("rel_flush", flush_count, st(16'd2));
        idle(); dmem_busy = 1'b1;
        tick();
        chk("mw2_state", 16'(state), 16'd2);
        dmem_busy = 1'b0; load_use(); #1;
        chk("mwlu_pc", 16'(pc_write), 16'd0);
        chk("mwlu_idexfl", 16'(id_ex_flush), 16'd1);
        chk("mwlu_freeze", 16'(pipe_freeze), 16'd0);
        tick();
        chk("mwlu_state", 16'(state), 16'd1);
        chk("mwlu_stall", stall_cycles, st(16'd8));
        stats_clr = 1'b1;
        tick();
        chk("clr_stall", stall_cycles, 16'd0);
        chk("clr_flush", flush_count, 16'd0);
        chk("clr_state", 16'(state), 16'd1);
        idle();
        tick();
        chk("clr_back", 16'(state), 16'd0);
        dmem_busy = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("to_terr", 16'(timeout_err), (k >= 4) ? 16'd1 : 16'd0);
            chk("to_state", 16'(state), 16'd2);
        end
        chk("to_stall", stall_cycles, st(16'd6));
        dmem_busy = 1'b0;
        tick();
        chk("to_release", 16'(state), 16'd0);
        chk("to_sticky", 16'(timeout_err), 16'd1);
        dmem_busy = 1'b1;
        tick();
        chk("rmw_state", 16'(state), 16'd2);
        #2 rst = 1'b1; #1;
        chk("arst_state", 16'(state), 16'd0);
        chk("arst_terr", 16'(timeout_err), 16'd0);
        chk("arst_stall", stall_cycles, 16'd0);
        chk("arst_flush", flush_count, 16'd0);
        tick();
        rst = 1'b0; dmem_busy = 1'b0; branch_taken = 1'b1; #1;
        chk("post_ifidfl", 16'(if_id_flush), 16'd1);
        chk("post_freeze", 16'(pipe_freeze), 16'd0);
        tick();
        chk("post_state", 16'(state), 16'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum consecutive dmem_busy cycles before error (range 2..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_rs  in  5  rs field of instruction in ID.
REQ-005 id_rt  in  5  rt field of instruction in ID.
REQ-006 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_rt  in  5  destination register of the EX load.
REQ-009 branch_taken  in  1  branch/jump resolved taken in ID.
REQ-010 dmem_busy  in  1  data memory not ready; pipeline must hold.
REQ-011 stats_clr  in  1  synchronous clear of statistics counters.
REQ-012 pc_write  out  1  PC update enable.
REQ-013 if_id_write  out  1  IF/ID register write enable.
REQ-014 if_id_flush  out  1  IF/ID register flush (zero on write).
REQ-015 id_ex_flush  out  1  insert bubble into ID/EX.
REQ-016 pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-017 state  out  2  FSM state: RUN=00, LOAD_STALL=01, MEM_WAIT=10.
REQ-018 timeout_err  out  1  sticky memory-wait timeout flag.
REQ-019 stall_cycles  out  16  count of cycles with pc_write=0.
REQ-020 flush_count  out  16  count of cycles with if_id_flush=1.

Function
REQ-021 Control outputs SHALL be combinational from registered state plus current inputs (same-cycle response); state, counters and flags registered.
REQ-022 Load-use hazard SHALL be: ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt)).
REQ-023 Default outputs: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-024 Priority in RUN and LOAD_STALL: dmem_busy > load-use > branch_taken.
REQ-025 dmem_busy=1: pc_write=0, if_id_write=0, pipe_freeze=1, flushes 0; next state MEM_WAIT.
REQ-026 Load-use (no busy): pc_write=0, if_id_write=0, id_ex_flush=1, branch_taken ignored; next state LOAD_STALL.
REQ-027 branch_taken only: if_id_flush=1, if_id_write=1, pc_write=1; next state RUN.
REQ-028 LOAD_STALL SHALL last one cycle; outputs and transitions identical to RUN.
REQ-029 MEM_WAIT with dmem_busy=1: outputs per REQ-025, remain in MEM_WAIT.
REQ-030 MEM_WAIT with dmem_busy=0: outputs and next state evaluated exactly as in RUN that same cycle.
REQ-031 8-bit wait_cnt SHALL count consecutive busy cycles (including first RUN cycle), clear when dmem_busy=0, saturate at TIMEOUT.
REQ-032 timeout_err SHALL set on the edge ending the TIMEOUT-th consecutive busy cycle; cleared only by rst; FSM remains in MEM_WAIT.
REQ-033 Encoding 11 is illegal; SHALL return to RUN next edge with default outputs.

Reset
REQ-034 rst=1 SHALL immediately force state=RUN, wait_cnt=0, timeout_err=0, stall_cycles=0, flush_count=0, independent of clk.
REQ-035 Reset mid-MEM_WAIT SHALL abandon the wait; first post-reset cycle evaluated as RUN.

Configuration
REQ-036 Macro HAZARD_STATS_EN defined: stall_cycles/flush_count increment per REQ-019/020, saturate at 16'hFFFF, stats_clr clears with priority over increment.
REQ-037 HAZARD_STATS_EN undefined: counters not built, stall_cycles and flush_count tied to 0, stats_clr ignored; all other behaviour unchanged.

Verification
REQ-038 ex_mem_read=1, ex_rt=5, id_rs=5 one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; next cycle state=01, pc_write=1.
REQ-039 ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall, pc_write=1, state stays 00.
REQ-040 load-use and branch_taken together -> stall only, if_id_flush=0; branch retaken next cycle -> if_id_flush=1.
REQ-041 dmem_busy high 3 cycles then low with branch_taken=1 -> pipe_freeze=1 for 3 cycles, then if_id_flush=1 on release cycle, state 10->00.
REQ-042 TIMEOUT=4, dmem_busy held 6 cycles -> timeout_err=1 after 4th edge, stays 1 until rst; with HAZARD_STATS_EN stall_cycles=6.
